iic_adc_master: RTL and testbench

//  I2C bus master serving the request/voltage interface of the ADC config/poll controller.
//  - Rising edge of m_wr_req: writes one config byte to the ADC.
//  - Rising edge of m_rd_req: reads a 16-bit conversion result and presents it on m_ad_voltage.
//  - Drives SCL/SDA open-drain toward the board ADC. Runs on the 10 MHz system clock.

---
 rtl/iic_pkg.sv | 26 ++
 rtl/iic_bit_timer.sv | 48 ++++
 rtl/iic_adc_master.sv | 182 ++++++++++++++++++
 tb/tb_iic_adc_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the I2C ADC master: FSM states, bus bit values and
// the four quarter-period phases of one bit slot.
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX_BYTE,
    RX_ACK,
    RX_BYTE,
    TX_ACK,
    STOP
  } iic_state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [1:0] PH_LOW0  = 2'd0;
  localparam logic [1:0] PH_LOW1  = 2'd1;
  localparam logic [1:0] PH_HIGH0 = 2'd2;
  localparam logic [1:0] PH_HIGH1 = 2'd3;

endpackage

// File: rtl/iic_bit_timer.sv
// Quarter-period divider and phase counter; held at phase 0 while en is low,
// so every transaction starts on a clean bit-slot boundary.
module iic_bit_timer
  import iic_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    tick    = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      phase_d = PH_LOW0;
    end else if (cnt_q == CW'(CLK_DIV - 1)) begin
      tick    = 1'b1;
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= PH_LOW0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/iic_adc_master.sv
// I2C master for the ADC: a write-request edge sends the config byte, a
// read-request edge fetches a 16-bit conversion result.
module iic_adc_master
  import iic_pkg::*;
#(
  parameter int         CLK_DIV  = 25,
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter logic [7:0] CFG_DATA = 8'h84
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_wr_req,
  input  logic        m_rd_req,
  output logic [15:0] m_ad_voltage,
  output logic        busy,
  output logic        ack_err,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i
);

  iic_state_e  state_q, state_d;
  logic        wr_req_q, rd_req_q;
  logic        pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic        is_rd_q, is_rd_d, nack_q, nack_d;
  logic [1:0]  byte_q, byte_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_q, tx_d, rx_q, rx_d, msb_q, msb_d;
  logic [15:0] volt_q, volt_d;
  logic        ack_err_q, ack_err_d;
  logic        tick, slot_end, scl_low, wr_rise, rd_rise, ack_bit;
  logic [1:0]  phase;

  iic_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .tick  (tick),
    .phase (phase)
  );

  assign busy     = (state_q != IDLE);
  assign slot_end = tick && (phase == PH_HIGH1);
  assign scl_low  = (phase == PH_LOW0) || (phase == PH_LOW1);
  assign wr_rise  = m_wr_req && !wr_req_q;
  assign rd_rise  = m_rd_req && !rd_req_q;
  assign ack_bit  = (byte_q == 2'd1) ? ACK : NACK;

  always_comb begin
    state_d   = state_q;
    pend_wr_d = pend_wr_q | wr_rise;
    pend_rd_d = pend_rd_q | rd_rise;
    is_rd_d   = is_rd_q;
    nack_d    = nack_q;
    byte_d    = byte_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    msb_d     = msb_q;
    volt_d    = volt_q;
    ack_err_d = 1'b0;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_wr_q || pend_rd_q) begin
          state_d   = START;
          is_rd_d   = !pend_wr_q;
          tx_d      = {DEV_ADDR, pend_wr_q ? RW_WRITE : RW_READ};
          bit_cnt_d = 3'd7;
          byte_d    = 2'd0;
          nack_d    = 1'b0;
          if (pend_wr_q) pend_wr_d = wr_rise;
          else           pend_rd_d = rd_rise;
        end
      end
      START: begin
        sda_oe = (phase == PH_HIGH0) || (phase == PH_HIGH1);
        if (slot_end) state_d = TX_BYTE;
      end
      TX_BYTE: begin
        scl_oe = scl_low;
        sda_oe = !tx_q[7];
        if (slot_end) begin
          if (bit_cnt_q == 3'd0) begin
            state_d = RX_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
          end
        end
      end
      RX_ACK: begin
        scl_oe = scl_low;
        if (slot_end) begin
          bit_cnt_d = 3'd7;
          if (sda_i == NACK) begin
            ack_err_d = 1'b1;
            nack_d    = 1'b1;
            state_d   = STOP;
          end else if (byte_q != 2'd0) begin
            state_d = STOP;
          end else begin
            byte_d  = 2'd1;
            tx_d    = CFG_DATA;
            state_d = is_rd_q ? RX_BYTE : TX_BYTE;
          end
        end
      end
      RX_BYTE: begin
        scl_oe = scl_low;
        if (slot_end) begin
          rx_d = {rx_q[6:0], sda_i};
          if (bit_cnt_q == 3'd0) state_d = TX_ACK;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      TX_ACK: begin
        scl_oe = scl_low;
        sda_oe = !ack_bit;
        if (slot_end) begin
          // ACK after the MSB asks for another byte; NACK after the LSB ends the read
          if (byte_q == 2'd1) begin
            msb_d     = rx_q;
            byte_d    = 2'd2;
            bit_cnt_d = 3'd7;
            state_d   = RX_BYTE;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        scl_oe = scl_low;
        sda_oe = (phase != PH_HIGH1);
        if (slot_end) begin
          state_d = IDLE;
          if (is_rd_q && !nack_q) volt_d = {msb_q, rx_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      pend_wr_q <= 1'b0;
      pend_rd_q <= 1'b0;
      is_rd_q   <= 1'b0;
      nack_q    <= 1'b0;
      byte_q    <= 2'd0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      msb_q     <= 8'h00;
      volt_q    <= 16'h0000;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= m_wr_req;
      rd_req_q  <= m_rd_req;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      is_rd_q   <= is_rd_d;
      nack_q    <= nack_d;
      byte_q    <= byte_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      msb_q     <= msb_d;
      volt_q    <= volt_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign m_ad_voltage = volt_q;
  assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_iic_adc_master.sv
// Directed bench for iic_adc_master with an open-drain bus and a sampled
// slave model that acknowledges, returns read data and logs bus traffic.
`timescale 1ns/1ps
module tb_iic_adc_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_wr_req = 1'b0;
  logic        m_rd_req = 1'b0;
  logic [15:0] m_ad_voltage;
  logic        busy, ack_err, scl_oe, sda_oe;
  logic        bfm_low = 1'b0;
  logic        scl_bus, sda_bus;

  assign scl_bus = !scl_oe;
  assign sda_bus = !(sda_oe || bfm_low);

  always #5 clk = ~clk;

  iic_adc_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_wr_req     (m_wr_req),
    .m_rd_req     (m_rd_req),
    .m_ad_voltage (m_ad_voltage),
    .busy         (busy),
    .ack_err      (ack_err),
    .scl_oe       (scl_oe),
    .sda_oe       (sda_oe),
    .sda_i        (sda_bus)
  );

  int errors = 0;
  int checks = 0;

  typedef enum int {M_IDLE, M_RX, M_ACKD, M_TX, M_MACK} bfm_mode_e;
  bfm_mode_e  mode = M_IDLE;
  logic [7:0] rd_data [2];
  logic [7:0] rx_log [$];
  logic       mst_ack [$];
  logic [7:0] sh = 8'h00;
  logic       nack_addr = 1'b0, bfm_nacked = 1'b0, bfm_rw = 1'b0, mack = 1'b1;
  logic       scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0;
  int bit_n = 0, byte_n = 0, tbit = 0, txidx = 0;
  int cyc = 0, n_start = 0, n_stop = 0, n_launch = 0, n_ackerr = 0;
  int scl_rise_cyc = 0, scl_per = 0, last_rise = 0, last_fall = 0, last_len = 0, ackerr_cyc = 0;
  logic [15:0] volt_last = 16'h0000, volt_before = 16'h0000;

  // Slave model and bus monitor, sampled on the falling clock edge
  initial begin
    logic scl_now, sda_now;
    forever begin
      @(negedge clk);
      scl_now = scl_bus;
      sda_now = sda_bus;
      if (scl_now && scl_p && sda_p && !sda_now) begin
        n_start++; mode = M_RX; bit_n = 0; byte_n = 0; bfm_low = 1'b0; sh = 8'h00;
      end else if (scl_now && scl_p && !sda_p && sda_now) begin
        n_stop++; mode = M_IDLE; bfm_low = 1'b0;
      end else if (scl_now && !scl_p) begin
        scl_per = cyc - scl_rise_cyc;
        scl_rise_cyc = cyc;
        if (mode == M_RX) begin sh = {sh[6:0], sda_now}; bit_n++; end
        else if (mode == M_MACK) begin mack = sda_now; mst_ack.push_back(sda_now); end
      end else if (!scl_now && scl_p) begin
        case (mode)
          M_RX: if (bit_n == 8) begin
            rx_log.push_back(sh);
            if (byte_n == 0) bfm_rw = sh[0];
            bfm_nacked = nack_addr && (byte_n == 0);
            bfm_low = !bfm_nacked;
            byte_n++;
            mode = M_ACKD;
          end
          M_ACKD: begin
            bfm_low = 1'b0;
            if (bfm_nacked) mode = M_IDLE;
            else if (bfm_rw && byte_n == 1) begin
              mode = M_TX; tbit = 0; txidx = 0; bfm_low = !rd_data[0][7];
            end else begin
              mode = M_RX; bit_n = 0;
            end
          end
          M_TX: begin
            tbit++;
            if (tbit == 8) begin bfm_low = 1'b0; mode = M_MACK; end
            else bfm_low = !rd_data[txidx][7-tbit];
          end
          M_MACK: begin
            bfm_low = 1'b0;
            mode = M_IDLE;
            if (!mack && txidx == 0) begin
              txidx = 1; tbit = 0; mode = M_TX; bfm_low = !rd_data[1][7];
            end
          end
          default: ;
        endcase
      end
      if (busy && !busy_p) begin n_launch++; last_rise = cyc; end
      if (!busy && busy_p) begin last_fall = cyc; last_len = cyc - last_rise; volt_before = volt_last; end
      if (busy) volt_last = m_ad_voltage;
      if (ack_err) begin n_ackerr++; ackerr_cyc = cyc; end
      scl_p = scl_now; sda_p = sda_now; busy_p = busy;
      cyc++;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_busy(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick_n(1);
      if (busy === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick_n(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got=%b want=0", ack_err); end
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL reset_bus got=%b want=00", {scl_oe, sda_oe}); end
    checks++; if (m_ad_voltage !== 16'h0000) begin errors++; $display("FAIL reset_voltage got=%h want=0000", m_ad_voltage); end
    rst_n = 1'b1;
    tick_n(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset got=%b want=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_write(input string tag);
    bit ok;
    int s0, p0, a0;
    logic [7:0] b0, b1;
    rx_log.delete();
    s0 = n_start; p0 = n_stop; a0 = n_ackerr;
    m_rd_req = 1'b0; m_wr_req = 1'b0;
    tick_n(2);
    m_wr_req = 1'b1;
    wait_busy(1'b1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_launch busy never rose within 50 clk", tag); end
    wait_busy(1'b0, 2200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_done busy never fell within 2200 clk", tag); end
    checks++; if (last_len != 2000) begin errors++; $display("FAIL %s_busy_len got=%0d want=2000", tag, last_len); end
    b0 = (rx_log.size() > 0) ? rx_log[0] : 8'hxx;
    b1 = (rx_log.size() > 1) ? rx_log[1] : 8'hxx;
    checks++; if (rx_log.size() != 2) begin errors++; $display("FAIL %s_nbytes got=%0d want=2", tag, rx_log.size()); end
    checks++; if (b0 !== 8'h90) begin errors++; $display("FAIL %s_addr got=%h want=90", tag, b0); end
    checks++; if (b1 !== 8'h84) begin errors++; $display("FAIL %s_cfg got=%h want=84", tag, b1); end
    checks++; if ((n_start - s0) != 1 || (n_stop - p0) != 1) begin errors++; $display("FAIL %s_start_stop got=%0d/%0d want=1/1", tag, n_start - s0, n_stop - p0); end
    checks++; if (n_ackerr != a0) begin errors++; $display("FAIL %s_ack_err got=%0d want=0 pulses", tag, n_ackerr - a0); end
    checks++; if (scl_per != 100) begin errors++; $display("FAIL %s_scl_period got=%0d want=100", tag, scl_per); end
    $display("%s: bytes=%0d len=%0d scl_period=%0d", tag, rx_log.size(), last_len, scl_per);
  endtask

  task automatic test_read(input string tag, input logic [7:0] msb, input logic [7:0] lsb, input logic [15:0] old_v);
    bit ok;
    int a0;
    logic [7:0] b0;
    logic k0, k1;
    rd_data[0] = msb; rd_data[1] = lsb;
    rx_log.delete(); mst_ack.delete();
    a0 = n_ackerr;
    m_wr_req = 1'b0; m_rd_req = 1'b0;
    tick_n(2);
    m_rd_req = 1'b1;
    wait_busy(1'b1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_launch busy never rose within 50 clk", tag); end
    wait_busy(1'b0, 3100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_done busy never fell within 3100 clk", tag); end
    checks++; if (last_len != 2900) begin errors++; $display("FAIL %s_busy_len got=%0d want=2900", tag, last_len); end
    checks++; if (volt_before !== old_v) begin errors++; $display("FAIL %s_early_update got=%h want=%h", tag, volt_before, old_v); end
    checks++; if (m_ad_voltage !== {msb, lsb}) begin errors++; $display("FAIL %s_voltage got=%h want=%h", tag, m_ad_voltage, {msb, lsb}); end
    b0 = (rx_log.size() > 0) ? rx_log[0] : 8'hxx;
    checks++; if (b0 !== 8'h91) begin errors++; $display("FAIL %s_addr got=%h want=91", tag, b0); end
    k0 = (mst_ack.size() > 0) ? mst_ack[0] : 1'bx;
    k1 = (mst_ack.size() > 1) ? mst_ack[1] : 1'bx;
    checks++; if ({k0, k1} !== 2'b01) begin errors++; $display("FAIL %s_master_acks got=%b want=01", tag, {k0, k1}); end
    checks++; if (n_ackerr != a0) begin errors++; $display("FAIL %s_ack_err got=%0d want=0 pulses", tag, n_ackerr - a0); end
    $display("%s: voltage=%h len=%0d", tag, m_ad_voltage, last_len);
  endtask

  task automatic test_back_to_back;
    bit ok;
    int l0, s0, f1;
    rd_data[0] = 8'hA5; rd_data[1] = 8'h5A;
    l0 = n_launch; s0 = n_start;
    m_wr_req = 1'b0; m_rd_req = 1'b0;
    tick_n(2);
    m_wr_req = 1'b1;
    wait_busy(1'b1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_launch busy never rose within 50 clk"); end
    tick_n(500);
    m_rd_req = 1'b1; m_wr_req = 1'b0;
    wait_busy(1'b0, 2000, ok);
    checks++; if (!ok || last_len != 2000) begin errors++; $display("FAIL b2b_write_len got=%0d want=2000", last_len); end
    f1 = last_fall;
    wait_busy(1'b1, 10, ok);
    checks++; if (!ok || (last_rise - f1) != 1) begin errors++; $display("FAIL b2b_gap got=%0d want=1", last_rise - f1); end
    wait_busy(1'b0, 3100, ok);
    checks++; if (!ok || last_len != 2900) begin errors++; $display("FAIL b2b_read_len got=%0d want=2900", last_len); end
    checks++; if (m_ad_voltage !== 16'hA55A) begin errors++; $display("FAIL b2b_voltage got=%h want=a55a", m_ad_voltage); end
    tick_n(7000);
    checks++; if ((n_launch - l0) != 2 || (n_start - s0) != 2) begin errors++; $display("FAIL b2b_count got=%0d launches want=2", n_launch - l0); end
    $display("b2b: launches=%0d voltage=%h", n_launch - l0, m_ad_voltage);
  endtask

  task automatic test_nack;
    bit ok;
    int a0, p0;
    logic [7:0] b0;
    nack_addr = 1'b1;
    rx_log.delete();
    a0 = n_ackerr; p0 = n_stop;
    m_wr_req = 1'b0; m_rd_req = 1'b0;
    tick_n(2);
    m_rd_req = 1'b1;
    wait_busy(1'b1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack_launch busy never rose within 50 clk"); end
    wait_busy(1'b0, 1500, ok);
    checks++; if (!ok || last_len != 1100) begin errors++; $display("FAIL nack_busy_len got=%0d want=1100", last_len); end
    checks++; if ((n_ackerr - a0) != 1) begin errors++; $display("FAIL nack_pulse got=%0d high cycles want=1", n_ackerr - a0); end
    checks++; if ((last_fall - ackerr_cyc) <= 0 || (last_fall - ackerr_cyc) > 300) begin errors++; $display("FAIL nack_stop_delay got=%0d want 1..300", last_fall - ackerr_cyc); end
    checks++; if (m_ad_voltage !== 16'hA55A) begin errors++; $display("FAIL nack_voltage got=%h want=a55a", m_ad_voltage); end
    b0 = (rx_log.size() > 0) ? rx_log[0] : 8'hxx;
    checks++; if (b0 !== 8'h91 || (n_stop - p0) != 1) begin errors++; $display("FAIL nack_bus got addr=%h stops=%0d want 91/1", b0, n_stop - p0); end
    nack_addr = 1'b0;
    $display("nack: ack_err_cycles=%0d len=%0d voltage=%h", n_ackerr - a0, last_len, m_ad_voltage);
  endtask

  task automatic test_reset_mid;
    bit ok;
    m_wr_req = 1'b0; m_rd_req = 1'b0;
    tick_n(2);
    m_wr_req = 1'b1;
    wait_busy(1'b1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_launch busy never rose within 50 clk"); end
    tick_n(215);
    checks++; if ({scl_oe, sda_oe} !== 2'b11) begin errors++; $display("FAIL rstmid_pre_bus got=%b want=11", {scl_oe, sda_oe}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({scl_oe, sda_oe, busy} !== 3'b000) begin errors++; $display("FAIL rstmid_release got=%b want=000", {scl_oe, sda_oe, busy}); end
    checks++; if (m_ad_voltage !== 16'h0000) begin errors++; $display("FAIL rstmid_voltage got=%h want=0000", m_ad_voltage); end
    m_wr_req = 1'b0;
    tick_n(3);
    rst_n = 1'b1;
    tick_n(3);
    $display("reset_mid: bus released");
    test_write("write_after_reset");
  endtask

  initial begin
    rd_data[0] = 8'h00; rd_data[1] = 8'h00;
    test_reset();
    test_write("write");
    test_read("read_1234", 8'h12, 8'h34, 16'h0000);
    test_read("read_zero", 8'h00, 8'h00, 16'h1234);
    test_back_to_back();
    test_nack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
